video_frame_capture: RTL and testbench
======================================

Name: video_frame_capture

Overview:
- Receive-side counterpart of the display timing generator: consumes a 640x480@60 parallel video stream (DE, HSYNC, VSYNC, 24-bit pixel) on the pixel clock.
- Writes one complete frame as 8-bit grayscale into the frame-buffer RAM write port.
- Measures the received active geometry and flags timing violations. Used for loopback test of the display path and for frame grabbing.

Parameters:
- IMG_X, 640, expected active pixels per line.
- IMG_Y, 480, expected active lines per frame.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_X*IMG_Y.

Ports:
- CLK_PX in 1: pixel clock, all logic on the rising edge.
- RST_n in 1: asynchronous active-low reset.
- CAPTURE_REQ in 1: single-cycle request to capture the next full frame.
- CONTINUOUS in 1: when 1, re-arm automatically after every frame.
- DE in 1: data enable, active high.
- HSYNC in 1: horizontal sync, active low.
- VSYNC in 1: vertical sync, active low.
- HDMI_PX in 24: {R,G,B}; only [7:0] is used.
- WR_EN out 1: frame-buffer write strobe.
- WR_ADDR out ADDR_W: frame-buffer write address.
- WR_DATA out 8: grayscale pixel value.
- BUSY out 1: high in ARM or CAPTURE.
- FRAME_DONE out 1: one-cycle pulse at end of a captured frame.
- MEAS_WIDTH out 10: pixel count of the last completed active line.
- MEAS_LINES out 10: active-line count of the last completed frame.
- ERR out 1: sticky timing-error flag.

Behaviour:
- Reset (asynchronous, RST_n=0): state IDLE; all outputs 0; input pipeline, counters and edge detectors cleared. Reset mid-frame abandons the capture with no FRAME_DONE.
- Input stage: DE, HSYNC, VSYNC and HDMI_PX[7:0] registered once (stage S1). Previous-cycle copies of DE and VSYNC are kept for edge detection.
- Write latency: a pixel sampled with DE=1 at edge N appears on WR_EN/WR_ADDR/WR_DATA after edge N+2. Outputs are registered. WR_EN is high exactly one cycle per accepted pixel.
- WR_DATA = HDMI_PX[7:0] of that pixel.
- Frame start: VSYNC falling edge (1->0 on S1).
- States:
  - IDLE: no writes. CAPTURE_REQ=1 -> ARM; clear ERR, MEAS_LINES and the address counter.
  - ARM: wait for a frame start -> CAPTURE. DE pixels seen in ARM are ignored (partial frame).
  - CAPTURE: each S1 DE=1 pixel writes at the current address, then address+1. Next frame start -> DONE.
  - DONE (one cycle): FRAME_DONE=1; MEAS_LINES updated.
    - CONTINUOUS=1 -> CAPTURE with address 0; the frame start that ended the previous frame also begins the new one.
    - CONTINUOUS=0 -> IDLE.
- CAPTURE_REQ outside IDLE is ignored.
- Line measurement, in all states:
  - Pixel counter counts S1 DE=1 cycles.
  - On DE falling edge: MEAS_WIDTH <= count (including the final pixel); count cleared; line counter+1.
  - On frame start: line counter cleared.
- Error conditions. Each sets ERR, which holds until CAPTURE_REQ is accepted or reset:
  - DE falling edge in CAPTURE with line width != IMG_X.
  - Entering DONE with line count != IMG_Y or total written != IMG_X*IMG_Y.
  - DE=1 on the same S1 cycle as VSYNC=0: that pixel is not written.
  - Address overflow: in CAPTURE, a pixel arriving when address == IMG_X*IMG_Y is not written, and the address saturates there.
- Counter widths: pixel and line counters are 10 bits and saturate at 1023.
- Simultaneous events:
  - DE falling edge and frame start on the same cycle: width/line updates happen first; the DONE checks use the updated line count.
  - A frame start in DONE is impossible by timing; ignore it.

Test Plan:
- Reset mid-frame: RST_n low during CAPTURE at address 1000 -> all outputs 0 immediately, state IDLE, no FRAME_DONE after release.
- Nominal single capture: CAPTURE_REQ, CONTINUOUS=0, two standard 640x480 frames with pixel value = address[7:0] -> exactly 307200 WR_EN pulses.
  - Addresses 0..307199 in order, WR_DATA matches, first write 2 cycles after the first DE sample.
  - One FRAME_DONE at the second frame start; MEAS_WIDTH=640, MEAS_LINES=480, ERR=0, then IDLE with no further writes.
- Arm mid-frame: CAPTURE_REQ issued at active line 200 -> no writes until the next VSYNC falling edge, then a full frame starting at address 0.
- Continuous mode: CONTINUOUS=1 over 3 frames -> 3 FRAME_DONE pulses, WR_ADDR returns to 0 at each frame start, BUSY stays high.
- Short line: line 10 has 639 DE pixels -> MEAS_WIDTH=639 after that line, ERR=1 sticky, and ERR is still 1 at FRAME_DONE.
- Overflow/protocol: 481 active lines -> writes stop at address 307199 and ERR=1. A separate frame with DE=1 while VSYNC=0 -> that pixel is not written and ERR=1.
- CAPTURE_REQ during BUSY -> ignored, ERR not cleared.

Source files
------------

// File: rtl/video_frame_capture.sv
// ---------------------------------------------------------------------------
// video_frame_capture
//
// Receive side of the display path. Takes a parallel video stream (DE, HSYNC,
// VSYNC, 24-bit pixel) on the pixel clock and writes one frame as 8-bit
// grayscale (the low byte of the pixel) into a frame-buffer write port. It
// also measures the active geometry and flags timing violations.
//
// Ports
//   CLK_PX       in   pixel clock; all logic on the rising edge
//   RST_n        in   asynchronous active-low reset
//   CAPTURE_REQ  in   one-cycle request to capture the next full frame
//   CONTINUOUS   in   re-arm automatically after every captured frame
//   DE           in   data enable, active high
//   HSYNC        in   horizontal sync, active low
//   VSYNC        in   vertical sync, active low; its falling edge starts a frame
//   HDMI_PX      in   {R,G,B}; only [7:0] is stored
//   WR_EN        out  frame-buffer write strobe, one cycle per stored pixel
//   WR_ADDR      out  frame-buffer write address
//   WR_DATA      out  grayscale pixel value
//   BUSY         out  armed or capturing
//   FRAME_DONE   out  one-cycle pulse at the end of a captured frame
//   MEAS_WIDTH   out  pixel count of the last completed active line
//   MEAS_LINES   out  active-line count of the last completed frame
//   ERR          out  sticky timing-error flag, cleared when a request is taken
//
// A pixel sampled with DE=1 at edge N is presented on WR_* after edge N+2.
// ---------------------------------------------------------------------------
module video_frame_capture #(
  parameter int IMG_X  = 640,
  parameter int IMG_Y  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              CLK_PX,
  input  logic              RST_n,
  input  logic              CAPTURE_REQ,
  input  logic              CONTINUOUS,
  input  logic              DE,
  input  logic              HSYNC,
  input  logic              VSYNC,
  input  logic [23:0]       HDMI_PX,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic [9:0]        MEAS_WIDTH,
  output logic [9:0]        MEAS_LINES,
  output logic              ERR
);

  // The address counter is one bit wider than the port so that it can rest
  // at IMG_X*IMG_Y even when that equals 2^ADDR_W.
  localparam int              TOTAL_I  = IMG_X * IMG_Y;
  localparam logic [ADDR_W:0] TOTAL    = (ADDR_W+1)'(TOTAL_I);
  localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W+1)'(1);
  localparam logic [9:0]      IMG_X_C  = 10'(IMG_X);
  localparam logic [9:0]      IMG_Y_C  = 10'(IMG_Y);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  state_t            state;
  logic              de_p1, hs_p1, vs_p1;
  logic [7:0]        px_p1;
  logic              de_p2, vs_p2;
  logic [9:0]        pix_cnt, line_cnt, line_next;
  logic [ADDR_W:0]   addr_cnt;
  logic              wr_vld_p2;
  logic [ADDR_W-1:0] wr_addr_p2;
  logic [7:0]        wr_data_p2;
  logic              de_fall, frame_start, addr_full;

  // Line boundaries are taken from DE; HSYNC and the colour bits above [7:0]
  // are carried for interface completeness only.
  logic unused_inputs;
  assign unused_inputs = ^{hs_p1, HDMI_PX[23:8]};

  // Stage 1: input registers (S1), plus previous-cycle copies for edges
  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      de_p1 <= 1'b0;
      hs_p1 <= 1'b0;
      vs_p1 <= 1'b0;
      px_p1 <= '0;
      de_p2 <= 1'b0;
      vs_p2 <= 1'b0;
    end else begin
      de_p1 <= DE;
      hs_p1 <= HSYNC;
      vs_p1 <= VSYNC;
      px_p1 <= HDMI_PX[7:0];
      de_p2 <= de_p1;
      vs_p2 <= vs_p1;
    end
  end

  // Stage 2: edge detection, geometry measurement and capture control
  assign de_fall     = de_p2 & ~de_p1;
  assign frame_start = vs_p2 & ~vs_p1;
  assign addr_full   = (addr_cnt == TOTAL);
  // Line count including a line that ends on this very cycle, so a frame
  // start coinciding with a DE fall is judged on the updated count.
  assign line_next   = de_fall ? sat_inc10(line_cnt) : line_cnt;

  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      pix_cnt    <= '0;
      line_cnt   <= '0;
      MEAS_WIDTH <= '0;
    end else begin
      // de_fall implies DE is low in S1, so the final pixel is already counted
      if (de_fall) begin
        MEAS_WIDTH <= pix_cnt;
        pix_cnt    <= '0;
      end else if (de_p1) begin
        pix_cnt <= sat_inc10(pix_cnt);
      end
      line_cnt <= frame_start ? '0 : line_next;
    end
  end

  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      MEAS_LINES <= '0;
      ERR        <= 1'b0;
      addr_cnt   <= '0;
      wr_vld_p2  <= 1'b0;
      wr_addr_p2 <= '0;
      wr_data_p2 <= '0;
    end else begin
      wr_vld_p2  <= 1'b0;
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (CAPTURE_REQ) begin
            state      <= ARM;
            BUSY       <= 1'b1;
            ERR        <= 1'b0;
            MEAS_LINES <= '0;
            addr_cnt   <= '0;
          end
        end
        ARM: begin
          // Pixels of the partial frame in flight are deliberately dropped.
          if (frame_start) state <= CAPTURE;
        end
        CAPTURE: begin
          if (de_p1 && vs_p1) begin
            if (!addr_full) begin
              wr_vld_p2  <= 1'b1;
              wr_addr_p2 <= addr_cnt[ADDR_W-1:0];
              wr_data_p2 <= px_p1;
              addr_cnt   <= addr_cnt + ADDR_ONE;
            end else begin
              ERR <= 1'b1;
            end
          end
          if (de_p1 && !vs_p1) ERR <= 1'b1;
          if (de_fall && (pix_cnt != IMG_X_C)) ERR <= 1'b1;
          if (frame_start) begin
            state      <= DONE;
            FRAME_DONE <= 1'b1;
            MEAS_LINES <= line_next;
            // In continuous mode BUSY stays up through the one-cycle DONE.
            BUSY       <= CONTINUOUS;
            if ((line_next != IMG_Y_C) || (addr_cnt != TOTAL)) ERR <= 1'b1;
          end
        end
        DONE: begin
          // The frame start that closed the last frame also opens the next.
          addr_cnt <= '0;
          if (CONTINUOUS) begin
            state <= CAPTURE;
            BUSY  <= 1'b1;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 3: registered frame-buffer write port
  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      WR_EN   <= 1'b0;
      WR_ADDR <= '0;
      WR_DATA <= '0;
    end else begin
      WR_EN   <= wr_vld_p2;
      WR_ADDR <= wr_addr_p2;
      WR_DATA <= wr_data_p2;
    end
  end

endmodule

// File: tb/tb_video_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_video_frame_capture
//
// Bench for video_frame_capture on a reduced 8x4 image (ADDR_W=6). Frames are
// generated with a VSYNC pulse, porches and per-line HSYNC/DE timing; pixel
// value = index of the pixel within its frame, so a correctly captured frame
// has WR_DATA == WR_ADDR[7:0].
// ---------------------------------------------------------------------------
module tb_video_frame_capture;

  localparam int IMG_X  = 8;
  localparam int IMG_Y  = 4;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              CAPTURE_REQ, CONTINUOUS, DE, HSYNC, VSYNC;
  logic [23:0]       HDMI_PX;
  logic              WR_EN, BUSY, FRAME_DONE, ERR;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;
  logic [9:0]        MEAS_WIDTH, MEAS_LINES;

  video_frame_capture #(.IMG_X(IMG_X), .IMG_Y(IMG_Y), .ADDR_W(ADDR_W)) dut (
    .CLK_PX(clk), .RST_n(rst_n), .CAPTURE_REQ(CAPTURE_REQ), .CONTINUOUS(CONTINUOUS),
    .DE(DE), .HSYNC(HSYNC), .VSYNC(VSYNC), .HDMI_PX(HDMI_PX),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE), .MEAS_WIDTH(MEAS_WIDTH), .MEAS_LINES(MEAS_LINES), .ERR(ERR)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-port observer: counts writes and order/data violations.
  int wr_total = 0, bad_addr = 0, bad_data = 0, done_total = 0, busy_low = 0;
  int exp_addr = 0, addr0_cyc = 0;
  int done_err = 0, done_width = 0, done_lines = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_addr <= 0;
    end else begin
      if (WR_EN) begin
        wr_total <= wr_total + 1;
        if (int'(WR_ADDR) != exp_addr) bad_addr <= bad_addr + 1;
        if (WR_DATA != exp_addr[7:0]) bad_data <= bad_data + 1;
        if (WR_ADDR == '0) addr0_cyc <= cyc;
        exp_addr <= exp_addr + 1;
      end
      if (FRAME_DONE) begin
        done_total <= done_total + 1;
        done_err   <= int'(ERR);
        done_width <= int'(MEAS_WIDTH);
        done_lines <= int'(MEAS_LINES);
        exp_addr   <= 0;
      end
      if (!BUSY) busy_low <= busy_low + 1;
    end
  end

  int n_cmp = 0, n_fail = 0;
  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Values recorded by the frame generator
  bit      arm_first = 0;
  int      first_de_edge = 0;
  int      short_w = 0;
  longint  rst_snap = 0;
  int      pre_en = 0, pre_addr = 0;
  int      rel_wr = 0, rel_done = 0;

  task automatic drive(input logic req, input logic de, input logic hs, input logic vs,
                       input logic [7:0] px);
    logic [15:0] hi;
    @(negedge clk);
    hi = 16'($urandom());
    CAPTURE_REQ = req;
    DE          = de;
    HSYNC       = hs;
    VSYNC       = vs;
    HDMI_PX     = {hi, px};
  endtask

  task automatic pulse_req();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
  endtask

  // One frame: VSYNC low 2 cycles (optional stray DE on the 2nd), 3 porch
  // cycles, then per line: HSYNC low 2, back porch 2, DE pixels, 2 blank.
  task automatic send_frame(input int lines, input int short_line, input int spur,
                            input int req_line, input int rst_pix);
    int idx = 0;
    int w;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, spur != 0, 1'b1, 1'b0, 8'hEE);
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int l = 0; l < lines; l++) begin
      if (!rst_n) begin
        rst_n    = 1'b1;
        rel_wr   = wr_total;
        rel_done = done_total;
      end
      drive(l == req_line, 1'b0, 1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      w = (l == short_line) ? IMG_X - 1 : IMG_X;
      for (int p = 0; p < w; p++) begin
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'(idx));
        if (arm_first) begin
          first_de_edge = cyc + 1;
          arm_first     = 0;
        end
        if (idx == rst_pix) begin
          #1;
          pre_en   = int'(WR_EN);
          pre_addr = int'(WR_ADDR);
          rst_n    = 1'b0;
          #1;
          rst_snap = longint'({WR_EN, WR_ADDR, WR_DATA, BUSY, FRAME_DONE,
                               MEAS_WIDTH, MEAS_LINES, ERR});
        end
        idx++;
      end
      repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      if (l == short_line) begin
        @(posedge clk);
        #1 short_w = int'(MEAS_WIDTH);
      end
    end
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
  endtask

  typedef struct {
    int lines; int short_line; int spur; int req_line;
    int exp_wr; int exp_err; int exp_width; int exp_lines;
  } vec_t;

  vec_t vec[6];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_wr, b_done, b_ba, b_bd, b_bl;
    vec_t v;

    // lines, short line, stray DE, req line | writes, ERR, width, lines at DONE
    vec[0] = '{4, -1, 0, -1, 32, 0, 8, 4};   // nominal
    vec[1] = '{4,  1, 0, -1, 31, 1, 8, 4};   // short line in the middle
    vec[2] = '{4,  3, 0, -1, 31, 1, 7, 4};   // short last line
    vec[3] = '{5, -1, 0, -1, 32, 1, 8, 5};   // one line too many: overflow
    vec[4] = '{4, -1, 1, -1, 32, 1, 8, 5};   // DE during VSYNC low (counts as a line)
    vec[5] = '{4,  1, 0,  3, 31, 1, 8, 4};   // request while busy is ignored

    rst_n = 1'b0; CAPTURE_REQ = 1'b0; CONTINUOUS = 1'b0;
    DE = 1'b0; HSYNC = 1'b1; VSYNC = 1'b1; HDMI_PX = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", longint'({WR_EN, WR_ADDR, WR_DATA, BUSY, FRAME_DONE,
                                     MEAS_WIDTH, MEAS_LINES, ERR}), 0);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

    for (int i = 0; i < 6; i++) begin
      v = vec[i];
      b_wr = wr_total; b_done = done_total; b_ba = bad_addr; b_bd = bad_data;
      pulse_req();
      check($sformatf("v%0d_busy_armed", i), BUSY, 1);
      arm_first = 1;
      send_frame(v.lines, v.short_line, v.spur, v.req_line, -1);
      send_frame(IMG_Y, -1, 0, -1, -1);
      check($sformatf("v%0d_writes", i), wr_total - b_wr, v.exp_wr);
      check($sformatf("v%0d_frame_done", i), done_total - b_done, 1);
      check($sformatf("v%0d_addr_order", i), bad_addr - b_ba, 0);
      check($sformatf("v%0d_data", i), bad_data - b_bd, 0);
      check($sformatf("v%0d_latency", i), addr0_cyc - first_de_edge, 2);
      check($sformatf("v%0d_err_at_done", i), done_err, v.exp_err);
      check($sformatf("v%0d_width_at_done", i), done_width, v.exp_width);
      check($sformatf("v%0d_lines_at_done", i), done_lines, v.exp_lines);
      check($sformatf("v%0d_err_sticky", i), ERR, v.exp_err);
      check($sformatf("v%0d_idle", i), BUSY, 0);
      if (v.short_line >= 0) check($sformatf("v%0d_short_width", i), short_w, IMG_X - 1);
    end

    // Request in the middle of a frame: that frame is skipped
    b_wr = wr_total; b_done = done_total; b_ba = bad_addr; b_bd = bad_data;
    send_frame(IMG_Y, -1, 0, 2, -1);
    check("arm_mid_no_partial", wr_total - b_wr, 0);
    check("arm_mid_busy", BUSY, 1);
    send_frame(IMG_Y, -1, 0, -1, -1);
    send_frame(0, -1, 0, -1, -1);
    check("arm_mid_writes", wr_total - b_wr, IMG_X * IMG_Y);
    check("arm_mid_done", done_total - b_done, 1);
    check("arm_mid_addr_order", bad_addr - b_ba, 0);
    check("arm_mid_data", bad_data - b_bd, 0);
    check("arm_mid_err", done_err, 0);

    // Continuous capture of three frames
    CONTINUOUS = 1'b1;
    pulse_req();
    b_wr = wr_total; b_done = done_total; b_ba = bad_addr; b_bd = bad_data; b_bl = busy_low;
    repeat (3) send_frame(IMG_Y, -1, 0, -1, -1);
    send_frame(0, -1, 0, -1, -1);
    check("cont_done", done_total - b_done, 3);
    check("cont_writes", wr_total - b_wr, 3 * IMG_X * IMG_Y);
    check("cont_addr_order", bad_addr - b_ba, 0);
    check("cont_data", bad_data - b_bd, 0);
    check("cont_busy_low_cycles", busy_low - b_bl, 0);
    check("cont_err", done_err, 0);
    check("cont_lines", done_lines, IMG_Y);
    CONTINUOUS = 1'b0;
    send_frame(0, -1, 0, -1, -1);
    check("cont_stop_done", done_total - b_done, 4);
    check("cont_stop_idle", BUSY, 0);
    check("cont_empty_frame_err", ERR, 1);

    // Reset while capturing pixel 12 (line 1); released at the next line
    pulse_req();
    send_frame(IMG_Y, -1, 0, -1, 12);
    check("rst_mid_was_writing", pre_en, 1);
    check("rst_mid_addr_before", pre_addr, 9);
    check("rst_mid_outputs", rst_snap, 0);
    send_frame(IMG_Y, -1, 0, -1, -1);
    send_frame(0, -1, 0, -1, -1);
    check("rst_mid_no_writes_after", wr_total - rel_wr, 0);
    check("rst_mid_no_done_after", done_total - rel_done, 0);
    check("rst_mid_idle", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
